// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the key-expansion controller and round function.
// The S-box is computed (multiplicative inverse + affine map) rather than tabulated.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef logic [127:0] aes_block_t;
  typedef logic [3:0]   aes_rk_idx_t;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} aes_kx_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, bb;
    p  = 8'h00;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 is the field inverse (and maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_rcon(input aes_rk_idx_t round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule.sv
// Combinational AES-128 key-schedule round: derives round key N from round key N-1.
// Blocks use row-major byte order, so a 32-bit column word is gathered across four rows.
module aes_key_schedule
  import aes_pkg::*;
(
  input  aes_rk_idx_t round_in,
  input  aes_block_t  key_in,
  output aes_block_t  key_out
);

  logic [31:0] col [4];
  logic [31:0] nw  [4];
  logic [31:0] rot, temp;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign col[c] = {key_in[127-8*c -: 8], key_in[95-8*c -: 8],
                     key_in[63-8*c -: 8],  key_in[31-8*c -: 8]};
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign key_out[127-32*r-8*c -: 8] = nw[c][31-8*r -: 8];
    end
  end

  assign rot  = {col[3][23:0], col[3][31:24]};
  assign temp = {aes_sbox(rot[31:24]) ^ aes_rcon(round_in), aes_sbox(rot[23:16]),
                 aes_sbox(rot[15:8]), aes_sbox(rot[7:0])};

  assign nw[0] = col[0] ^ temp;
  assign nw[1] = col[1] ^ nw[0];
  assign nw[2] = col[2] ^ nw[1];
  assign nw[3] = col[3] ^ nw[2];

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-expansion sequencer: one schedule round per cycle into an 11-entry
// round-key file, served through a registered read port.
module aes_key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         key_valid_in,
  input  logic [127:0] key_in,
  output logic         key_ready_out,
  input  logic         flush_in,
  input  logic [3:0]   rk_idx_in,
  output logic [127:0] rk_out,
  output logic         keys_valid_out,
  output logic         busy_out
);

  if (NUM_ROUNDS != AES_NUM_ROUNDS) begin : g_bad_rounds
    $error("aes_key_expand_ctrl: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  localparam aes_rk_idx_t LAST_RK = 4'(AES_NUM_ROUNDS);

  aes_kx_state_t state_q, state_d;
  aes_rk_idx_t   cnt_q, cnt_d;
  aes_block_t    wk_q, wk_d;
  aes_block_t    rf_q [0:AES_NUM_ROUNDS];
  aes_block_t    rf_d [0:AES_NUM_ROUNDS];
  aes_block_t    rk_out_q, rk_out_d;
  logic          kv_q, kv_d;
  logic          busy_q, busy_d;

  aes_rk_idx_t   ks_round;
  aes_block_t    ks_out;
  logic          accept;

  aes_key_schedule u_sched (
    .round_in (ks_round),
    .key_in   (wk_q),
    .key_out  (ks_out)
  );

  assign key_ready_out  = (state_q != EXPAND) && !flush_in;
  assign accept         = key_valid_in && key_ready_out;
  assign ks_round       = (state_q == EXPAND) ? cnt_q : '0;
  assign rk_out         = rk_out_q;
  assign keys_valid_out = kv_q;
  assign busy_out       = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = wk_q;
    kv_d    = kv_q;
    rf_d    = rf_q;
    // Flush wins over accept and over the in-flight write; stored keys are kept.
    if (flush_in) begin
      state_d = IDLE;
      cnt_d   = '0;
      kv_d    = 1'b0;
    end else if (accept) begin
      state_d  = EXPAND;
      cnt_d    = 4'd1;
      kv_d     = 1'b0;
      wk_d     = key_in;
      rf_d[0]  = key_in;
    end else if (state_q == EXPAND) begin
      rf_d[cnt_q] = ks_out;
      wk_d        = ks_out;
      if (cnt_q == LAST_RK) begin
        state_d = READY;
        kv_d    = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    busy_d   = (state_d == EXPAND);
    // Reads see the pre-edge contents: no bypass of a same-cycle write.
    rk_out_d = (rk_idx_in <= LAST_RK) ? rf_q[rk_idx_in] : '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wk_q     <= '0;
      kv_q     <= 1'b0;
      busy_q   <= 1'b0;
      rk_out_q <= '0;
      for (int i = 0; i <= AES_NUM_ROUNDS; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wk_q     <= wk_d;
      kv_q     <= kv_d;
      busy_q   <= busy_d;
      rk_out_q <= rk_out_d;
      rf_q     <= rf_d;
    end
  end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Self-checking bench: FIPS-197 word-oriented key expansion model plus accept/expand
// timing rules, compared against the controller every cycle, with directed and random stimulus.
module tb_aes_key_expand_ctrl;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         key_ready_out;
  logic         flush_in;
  logic [3:0]   rk_idx_in;
  logic [127:0] rk_out;
  logic         keys_valid_out;
  logic         busy_out;

  aes_key_expand_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .key_valid_in   (key_valid_in),
    .key_in         (key_in),
    .key_ready_out  (key_ready_out),
    .flush_in       (flush_in),
    .rk_idx_in      (rk_idx_in),
    .rk_out         (rk_out),
    .keys_valid_out (keys_valid_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] rf_m   [11];
  logic [127:0] rk_m;
  int           since_m;   // edges since last accept, -1 when none pending
  bit           kv_m;
  bit           chk_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Inverse found by exhaustive search, then the standard affine map.
  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  // Row-major <-> FIPS column-major word order (self-inverse transpose).
  function automatic logic [127:0] to_rm(input logic [127:0] cm);
    logic [127:0] rm;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        rm[127-8*(4*r+c) -: 8] = cm[127-8*(4*c+r) -: 8];
    return rm;
  endfunction

  function automatic void expand_key(input logic [127:0] key_rm);
    logic [31:0]  w [44];
    logic [127:0] cm;
    logic [7:0]   rcon = 8'h01;
    logic [31:0]  t;
    cm = to_rm(key_rm);
    for (int i = 0; i < 4; i++) w[i] = cm[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = to_rm({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endfunction

  function automatic void model_reset();
    since_m = -1;
    kv_m    = 0;
    rk_m    = '0;
    for (int i = 0; i < 11; i++) rf_m[i] = '0;
  endfunction

  // One clock: evaluate the rules on pre-edge inputs, then advance the model at the edge.
  task automatic step();
    bit           expanding, acc, fl;
    logic [127:0] rd, k;
    expanding = (since_m >= 0 && since_m < 10);
    fl  = flush_in;
    acc = key_valid_in && !expanding && !fl;
    rd  = (rk_idx_in <= 4'd10) ? rf_m[rk_idx_in] : '0;
    k   = key_in;
    @(posedge clk_in);
    if (fl) begin
      since_m = -1;
      kv_m    = 0;
    end else if (acc) begin
      rf_m[0] = k;
      expand_key(k);
      since_m = 0;
      kv_m    = 0;
    end else if (expanding) begin
      since_m++;
      rf_m[since_m] = exp_rk[since_m];
      if (since_m == 10) kv_m = 1;
    end
    rk_m = rd;
    #1;
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("busy", busy_out, since_m >= 0 && since_m < 10);
      chk("keys_valid", keys_valid_out, kv_m);
      chk("ready", key_ready_out, !(since_m >= 0 && since_m < 10) && !flush_in);
      chk("rk_out", rk_out, rk_m);
    end
  end

  task automatic run_key(input logic [127:0] k, output int busy_cycles);
    busy_cycles  = 0;
    key_valid_in = 1;
    key_in       = k;
    step();
    key_valid_in = 0;
    if (busy_out) busy_cycles++;
    for (int i = 0; i < 11; i++) begin
      step();
      if (busy_out) busy_cycles++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
    rk_idx_in = idx;
    step();
    v = rk_out;
    rk_idx_in = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int           bc;
    int           lows;
    logic [127:0] v, ka, kb;
    rst_in = 1; key_valid_in = 0; key_in = '0; flush_in = 0; rk_idx_in = 0;
    build_sbox();
    model_reset();
    #2;
    chk("reset_rk_out", rk_out, '0);
    chk("reset_busy", busy_out, 0);
    chk("reset_kv", keys_valid_out, 0);
    chk("reset_ready", key_ready_out, 1);
    #1 rst_in = 0;
    chk_en = 1;

    // Zero key, model pinned to known vectors.
    run_key('0, bc);
    chk("model_zero_rk1", exp_rk[1], 128'h62626262_63636363_63636363_63636363);
    chk("model_zero_rk10", exp_rk[10], 128'hb43e236f_ef92e98f_5be25118_cb11cf8e);
    chk("zero_kv", keys_valid_out, 1);
    read_rk(4'd1, v);  chk("zero_rk1", v, 128'h62626262_63636363_63636363_63636363);
    read_rk(4'd10, v); chk("zero_rk10", v, 128'hb43e236f_ef92e98f_5be25118_cb11cf8e);
    read_rk(4'd0, v);  chk("zero_rk0", v, '0);

    // FIPS-197 A.1 key.
    run_key(to_rm(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c), bc);
    chk("fips_busy_cycles", bc, 10);
    chk("model_fips_rk1", exp_rk[1], to_rm(128'ha0fafe17_88542cb1_23a33939_2a6c7605));
    read_rk(4'd1, v);  chk("fips_rk1", v, to_rm(128'ha0fafe17_88542cb1_23a33939_2a6c7605));
    read_rk(4'd10, v); chk("fips_rk10", v, to_rm(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));

    // Second key held during expansion.
    ka = rnd128(); kb = rnd128();
    key_valid_in = 1; key_in = ka;
    step();
    key_in = kb;
    lows = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (!key_ready_out) lows++;
    end
    chk("hold_ready_low_cycles", lows, 9);
    step();
    chk("hold_kv_ready", keys_valid_out, 1);
    chk("hold_ready_high", key_ready_out, 1);
    step();
    key_valid_in = 0;
    chk("hold_rekey_kv_drop", keys_valid_out, 0);
    chk("hold_rekey_busy", busy_out, 1);
    repeat (10) step();
    read_rk(4'd10, v);
    chk("hold_second_key_rk10", v, exp_rk[10]);

    // Flush at expansion cycle 5 together with a new key.
    key_valid_in = 1; key_in = rnd128();
    step();
    key_valid_in = 0;
    repeat (4) step();
    flush_in = 1; key_valid_in = 1; key_in = rnd128();
    step();
    chk("flush_busy", busy_out, 0);
    chk("flush_kv", keys_valid_out, 0);
    flush_in = 0;
    step();
    key_valid_in = 0;
    chk("flush_then_accept_busy", busy_out, 1);
    repeat (10) step();
    chk("flush_then_kv", keys_valid_out, 1);

    // Asynchronous reset between edges, mid-expansion.
    key_valid_in = 1; key_in = rnd128();
    step();
    key_valid_in = 0;
    repeat (3) step();
    #2 rst_in = 1;
    #1;
    model_reset();
    chk("arst_rk_out", rk_out, '0);
    chk("arst_busy", busy_out, 0);
    chk("arst_kv", keys_valid_out, 0);
    chk("arst_ready", key_ready_out, 1);
    @(posedge clk_in);
    #1 rst_in = 0;

    // Read sweep in READY.
    run_key(rnd128(), bc);
    for (int i = 0; i < 16; i++) begin
      read_rk(4'(i), v);
      chk("sweep", v, (i <= 10) ? exp_rk[i] : '0);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      key_valid_in = ($urandom_range(0, 3) == 0);
      key_in       = rnd128();
      flush_in     = ($urandom_range(0, 39) == 0);
      rk_idx_in    = 4'($urandom_range(0, 15));
      step();
    end
    key_valid_in = 0; flush_in = 0;
    step();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
